// File: rtl/sha1_sched_pkg.sv
// Shared types and constants for the SHA-1 job scheduler.
package sha1_sched_pkg;

    localparam int unsigned HASH_W       = 160;
    localparam int unsigned WORD_W       = 32;
    localparam int unsigned ABORT_CYCLES = 2;

    // SHA-1 initial hash values, handy for reference models.
    localparam logic [WORD_W-1:0] SHA1_H0 = 32'h67452301;
    localparam logic [WORD_W-1:0] SHA1_H1 = 32'hEFCDAB89;
    localparam logic [WORD_W-1:0] SHA1_H2 = 32'h98BADCFE;
    localparam logic [WORD_W-1:0] SHA1_H3 = 32'h10325476;
    localparam logic [WORD_W-1:0] SHA1_H4 = 32'hC3D2E1F0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_ABORT,
        ST_RESP
    } state_e;

    typedef struct packed {
        logic [HASH_W-1:0] hash;
        logic              error;
        logic [WORD_W-1:0] cycles;
    } rsp_t;

endpackage

// File: rtl/sha1_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request after ptr_i, wrapping.
module sha1_rr_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o
);

    logic             found;
    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((32'(ptr_i) + k) % NUM_REQ);
            if (en_i && !found && req_i[cand]) begin
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sha1_job_scheduler.sv
// Shares one SHA-1 core between NUM_REQ requesters: round-robin accept, start/wait
// for a done edge, watchdog abort with core reset pulse, and a held response.
module sha1_job_scheduler
    import sha1_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned START_CYCLES   = 2,
    parameter int unsigned TIMEOUT_CYCLES = 65536,
    parameter int unsigned ID_W           = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    nreset,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*32-1:0]   req_addr,
    input  logic [NUM_REQ*32-1:0]   req_size,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [HASH_W-1:0]       rsp_hash,
    output logic                    rsp_error,
    output logic [WORD_W-1:0]       rsp_cycles,
    output logic                    core_start_hash,
    output logic [WORD_W-1:0]       core_message_addr,
    output logic [WORD_W-1:0]       core_message_size,
    output logic                    core_nreset,
    input  logic                    core_done,
    input  logic [HASH_W-1:0]       core_hash
);

    localparam int unsigned SEL_W = $clog2(NUM_REQ * WORD_W);

    state_e              state_q, state_d;
    logic [ID_W-1:0]     ptr_q, ptr_d, id_q, id_d, rsp_id_q, rsp_id_d;
    logic [WORD_W-1:0]   addr_q, addr_d, size_q, size_d;
    logic [WORD_W-1:0]   cnt_q, cnt_d, wd_q, wd_d, phase_q, phase_d;
    logic                start_q, start_d, abort_q, abort_d;
    logic                rsp_valid_q, rsp_valid_d, done_q;
    rsp_t                rsp_q, rsp_d;

    logic [NUM_REQ-1:0]  gnt;
    logic [ID_W-1:0]     gnt_idx;
    logic [SEL_W-1:0]    sel_base;
    logic                done_edge;
    logic [WORD_W-1:0]   cnt_inc;

    sha1_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (ID_W)
    ) u_arb (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .en_i  (state_q == ST_IDLE),
        .gnt_o (gnt),
        .idx_o (gnt_idx)
    );

    assign sel_base  = SEL_W'(32'(gnt_idx) * 32'd32);
    assign done_edge = core_done & ~done_q;
    assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + 32'd1;

    // Next-state and register-input logic.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        addr_d      = addr_q;
        size_d      = size_q;
        cnt_d       = cnt_q;
        wd_d        = wd_q;
        phase_d     = phase_q;
        start_d     = start_q;
        abort_d     = abort_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_d       = rsp_q;
        unique case (state_q)
            ST_IDLE: begin
                if (|(req_valid & gnt)) begin
                    addr_d  = req_addr[sel_base +: WORD_W];
                    size_d  = req_size[sel_base +: WORD_W];
                    id_d    = gnt_idx;
                    ptr_d   = gnt_idx;
                    cnt_d   = '0;
                    phase_d = '0;
                    start_d = 1'b1;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                cnt_d = cnt_inc;
                if (phase_q == 32'(START_CYCLES - 1)) begin
                    start_d = 1'b0;
                    wd_d    = '0;
                    state_d = ST_WAIT;
                end else begin
                    phase_d = phase_q + 32'd1;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_inc;
                wd_d  = wd_q + 32'd1;
                // A done edge beats a watchdog expiry in the same cycle.
                if (done_edge) begin
                    rsp_d       = '{hash: core_hash, error: 1'b0, cycles: cnt_q};
                    rsp_id_d    = id_q;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else if (wd_d == 32'(TIMEOUT_CYCLES)) begin
                    abort_d = 1'b1;
                    phase_d = '0;
                    state_d = ST_ABORT;
                end
            end
            ST_ABORT: begin
                if (phase_q == 32'(ABORT_CYCLES - 1)) begin
                    abort_d     = 1'b0;
                    rsp_d       = '{hash: '0, error: 1'b1, cycles: 32'(TIMEOUT_CYCLES)};
                    rsp_id_d    = id_q;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RESP;
                end else begin
                    phase_d = phase_q + 32'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q     <= ST_IDLE;
            ptr_q       <= ID_W'(NUM_REQ - 1);
            id_q        <= '0;
            addr_q      <= '0;
            size_q      <= '0;
            cnt_q       <= '0;
            wd_q        <= '0;
            phase_q     <= '0;
            start_q     <= 1'b0;
            abort_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            cnt_q       <= cnt_d;
            wd_q        <= wd_d;
            phase_q     <= phase_d;
            start_q     <= start_d;
            abort_q     <= abort_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_q       <= rsp_d;
            done_q      <= core_done;
        end
    end

    assign req_ready         = gnt;
    assign rsp_valid         = rsp_valid_q;
    assign rsp_id            = rsp_id_q;
    assign rsp_hash          = rsp_q.hash;
    assign rsp_error         = rsp_q.error;
    assign rsp_cycles        = rsp_q.cycles;
    assign core_start_hash   = start_q;
    assign core_message_addr = addr_q;
    assign core_message_size = size_q;
    assign core_nreset       = nreset & ~abort_q;

endmodule

// File: tb/tb_sha1_job_scheduler.sv
// Self-checking bench for sha1_job_scheduler: behavioural SHA-1 core stub over a byte
// memory, table-driven and random jobs, plus hand-written corner-case sequences.
module tb_sha1_job_scheduler;
    import sha1_sched_pkg::*;

    localparam int unsigned NUM_REQ      = 2;
    localparam int unsigned START_CYCLES = 2;
    localparam int unsigned TIMEOUT      = 16;
    localparam int unsigned ID_W         = 1;

    logic                 clk = 1'b0;
    logic                 nreset = 1'b0;
    logic [NUM_REQ-1:0]   req_valid = '0;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ*32-1:0] req_addr = '0;
    logic [NUM_REQ*32-1:0] req_size = '0;
    logic                 rsp_valid;
    logic                 rsp_ready = 1'b0;
    logic [ID_W-1:0]      rsp_id;
    logic [159:0]         rsp_hash;
    logic                 rsp_error;
    logic [31:0]          rsp_cycles;
    logic                 core_start_hash;
    logic [31:0]          core_message_addr;
    logic [31:0]          core_message_size;
    logic                 core_nreset;
    logic                 core_done = 1'b0;
    logic [159:0]         core_hash = '0;

    sha1_job_scheduler #(
        .NUM_REQ        (NUM_REQ),
        .START_CYCLES   (START_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT),
        .ID_W           (ID_W)
    ) dut (
        .clk               (clk),
        .nreset            (nreset),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_addr          (req_addr),
        .req_size          (req_size),
        .rsp_valid         (rsp_valid),
        .rsp_ready         (rsp_ready),
        .rsp_id            (rsp_id),
        .rsp_hash          (rsp_hash),
        .rsp_error         (rsp_error),
        .rsp_cycles        (rsp_cycles),
        .core_start_hash   (core_start_hash),
        .core_message_addr (core_message_addr),
        .core_message_size (core_message_size),
        .core_nreset       (core_nreset),
        .core_done         (core_done),
        .core_hash         (core_hash)
    );

    always #5 clk = ~clk;

    localparam logic [159:0] ABC_HASH = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;

    logic [7:0] mem [256];
    int n_cmp = 0;
    int n_err = 0;
    int low_cnt = 0;

    // ---------------- reference SHA-1 over the byte memory ----------------
    function automatic logic [7:0] msg_byte(input logic [31:0] a, input logic [31:0] s,
                                            input int unsigned len, input int unsigned p);
        logic [63:0] bits;
        bits = 64'(s) << 3;
        if (p < s) return mem[8'(a + p)];
        if (p == s) return 8'h80;
        if (p >= len - 8) return 8'(bits >> (8 * (len - 1 - p)));
        return 8'h00;
    endfunction

    function automatic logic [159:0] sha1_ref(input logic [31:0] a, input logic [31:0] s);
        logic [31:0] h0, h1, h2, h3, h4, va, vb, vc, vd, ve, f, kk, tmp;
        logic [31:0] w [80];
        int unsigned len;
        len = ((s + 8) / 64 + 1) * 64;
        h0 = SHA1_H0; h1 = SHA1_H1; h2 = SHA1_H2; h3 = SHA1_H3; h4 = SHA1_H4;
        for (int unsigned blk = 0; blk < len / 64; blk++) begin
            for (int i = 0; i < 16; i++) begin
                w[i] = '0;
                for (int j = 0; j < 4; j++)
                    w[i] = {w[i][23:0], msg_byte(a, s, len, blk * 64 + 32'(i * 4 + j))};
            end
            for (int i = 16; i < 80; i++) begin
                tmp  = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
                w[i] = {tmp[30:0], tmp[31]};
            end
            va = h0; vb = h1; vc = h2; vd = h3; ve = h4;
            for (int i = 0; i < 80; i++) begin
                if (i < 20)      begin f = (vb & vc) | (~vb & vd);           kk = 32'h5A827999; end
                else if (i < 40) begin f = vb ^ vc ^ vd;                     kk = 32'h6ED9EBA1; end
                else if (i < 60) begin f = (vb & vc) | (vb & vd) | (vc & vd); kk = 32'h8F1BBCDC; end
                else             begin f = vb ^ vc ^ vd;                     kk = 32'hCA62C1D6; end
                tmp = {va[26:0], va[31:27]} + f + ve + kk + w[i];
                ve = vd; vd = vc; vc = {vb[1:0], vb[31:2]}; vb = va; va = tmp;
            end
            h0 += va; h1 += vb; h2 += vc; h3 += vd; h4 += ve;
        end
        return {h0, h1, h2, h3, h4};
    endfunction

    // ---------------- core stub ----------------
    // done appears LAT cycles after the first start_hash cycle; in hold mode it stays
    // high after completion and drops only shortly before the next job's done.
    int          stub_lat  = 10;
    bit          stub_hang = 1'b0;
    bit          stub_hold = 1'b0;
    bit          busy      = 1'b0;
    bit          st_prev   = 1'b0;
    int          stub_k    = 0;
    logic [159:0] pend     = '0;

    always @(posedge clk or negedge core_nreset) begin
        if (!core_nreset) begin
            busy      <= 1'b0;
            st_prev   <= 1'b0;
            stub_k    <= 0;
            core_done <= 1'b0;
            core_hash <= '0;
        end else begin
            st_prev <= core_start_hash;
            if (core_start_hash && !st_prev) begin
                busy   <= 1'b1;
                stub_k <= 1;
                pend   <= sha1_ref(core_message_addr, core_message_size);
                if (!stub_hold) core_done <= 1'b0;
            end else if (busy) begin
                stub_k <= stub_k + 1;
                if (stub_k == stub_lat - 3) core_done <= 1'b0;
                if (stub_k == stub_lat - 1 && !stub_hang) begin
                    core_done <= 1'b1;
                    core_hash <= pend;
                    busy      <= 1'b0;
                end
            end else if (!stub_hold) begin
                core_done <= 1'b0;
            end
        end
    end

    always @(negedge clk) if (nreset && !core_nreset) low_cnt <= low_cnt + 1;

    // ---------------- checking helpers ----------------
    typedef struct {
        int           req;
        logic [31:0]  addr;
        logic [31:0]  size;
        int           lat;
        bit           hang;
        logic [ID_W-1:0] exp_id;
        logic         exp_err;
        logic [31:0]  exp_cyc;
        logic [159:0] exp_hash;
    } vec_t;

    task automatic chk(input string tag, input string fld, input logic [159:0] got,
                       input logic [159:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s.%s: got %0h expected %0h", tag, fld, got, exp);
        end
    endtask

    // A job errors if it hangs or if done would arrive after the WAIT window closes.
    function automatic vec_t mk_vec(input int r, input logic [31:0] a, input logic [31:0] s,
                                    input int lat, input bit hang);
        vec_t v;
        v.req = r; v.addr = a; v.size = s; v.lat = lat; v.hang = hang;
        v.exp_id   = ID_W'(r);
        v.exp_err  = hang || (lat > int'(START_CYCLES + TIMEOUT - 1));
        v.exp_cyc  = v.exp_err ? 32'(TIMEOUT) : 32'(lat);
        v.exp_hash = v.exp_err ? '0 : sha1_ref(a, s);
        return v;
    endfunction

    task automatic chk_rst(input string tag);
        chk(tag, "req_ready", 160'(req_ready), 0);
        chk(tag, "rsp_valid", 160'(rsp_valid), 0);
        chk(tag, "rsp_id", 160'(rsp_id), 0);
        chk(tag, "rsp_hash", rsp_hash, 0);
        chk(tag, "rsp_error", 160'(rsp_error), 0);
        chk(tag, "rsp_cycles", 160'(rsp_cycles), 0);
        chk(tag, "core_start_hash", 160'(core_start_hash), 0);
        chk(tag, "core_message_addr", 160'(core_message_addr), 0);
        chk(tag, "core_message_size", 160'(core_message_size), 0);
        chk(tag, "core_nreset", 160'(core_nreset), 0);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int n;
        int lc;
        logic [NUM_REQ-1:0] want;
        want      = NUM_REQ'(1) << v.req;
        stub_lat  = v.lat;
        stub_hang = v.hang;
        @(negedge clk);
        req_addr[v.req*32 +: 32] = v.addr;
        req_size[v.req*32 +: 32] = v.size;
        req_valid = want;
        #1;
        n = 0;
        while (req_ready !== want && n < 20) begin @(negedge clk); #1; n++; end
        chk(tag, "req_ready", 160'(req_ready), 160'(want));
        lc = low_cnt;
        @(negedge clk);
        req_valid = '0;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        chk(tag, "rsp_valid", 160'(rsp_valid), 1);
        chk(tag, "rsp_id", 160'(rsp_id), 160'(v.exp_id));
        chk(tag, "rsp_error", 160'(rsp_error), 160'(v.exp_err));
        chk(tag, "rsp_cycles", 160'(rsp_cycles), 160'(v.exp_cyc));
        chk(tag, "rsp_hash", rsp_hash, v.exp_hash);
        chk(tag, "core_message_addr", 160'(core_message_addr), 160'(v.addr));
        chk(tag, "core_message_size", 160'(core_message_size), 160'(v.size));
        chk(tag, "core_nreset_low_cycles", 160'(low_cnt - lc), v.exp_err ? 2 : 0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk(tag, "rsp_valid_clear", 160'(rsp_valid), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vt[7];
        vec_t rv;
        logic [31:0] seed;
        logic [ID_W-1:0] hold_id;
        logic [159:0] hold_hash;
        int bad;
        int n;

        seed = 32'h01234567;
        for (int i = 0; i < 256; i++) begin
            seed   = seed * 32'd1103515245 + 32'd12345;
            mem[i] = seed[23:16];
        end
        mem[0] = 8'h61; mem[1] = 8'h62; mem[2] = 8'h63;

        vt[0] = mk_vec(0, 0,   3,  12, 0);
        vt[0].exp_hash = ABC_HASH;
        vt[1] = mk_vec(1, 64,  0,  8,  0);
        vt[2] = mk_vec(1, 128, 54, 14, 0);
        vt[3] = mk_vec(0, 32,  10, 17, 0);
        vt[4] = mk_vec(1, 40,  10, 18, 0);
        vt[5] = mk_vec(0, 0,   3,  10, 1);
        vt[6] = mk_vec(1, 128, 54, 5,  0);

        #3;
        chk_rst("reset");
        @(negedge clk);
        nreset = 1'b1;

        for (int i = 0; i < 7; i++) run_vec(vt[i], $sformatf("vec%0d", i));

        // Stale done: level left high by the first job must not complete the second.
        stub_hold = 1'b1;
        run_vec(mk_vec(0, 8, 5, 10, 0), "stale_a");
        run_vec(mk_vec(1, 16, 7, 16, 0), "stale_b");
        stub_hold = 1'b0;

        // Backpressure: response frozen, no new grants while waiting.
        stub_lat  = 9;
        stub_hang = 1'b0;
        @(negedge clk);
        req_addr[31:0] = 32'd64;
        req_size[31:0] = 32'd20;
        req_valid = 2'b01;
        @(negedge clk);
        req_valid = 2'b11;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        chk("bp", "rsp_valid", 160'(rsp_valid), 1);
        hold_id   = rsp_id;
        hold_hash = rsp_hash;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_id !== hold_id || rsp_hash !== hold_hash || req_ready !== '0)
                bad++;
        end
        chk("bp", "stall_violations", 160'(bad), 0);
        chk("bp", "rsp_id", 160'(hold_id), 0);
        chk("bp", "rsp_hash", hold_hash, sha1_ref(64, 20));
        rsp_ready = 1'b1;
        req_valid = '0;
        @(negedge clk);
        rsp_ready = 1'b0;

        for (int i = 0; i < 8; i++) begin
            rv = mk_vec(int'($urandom_range(0, 1)), 32'(4 * $urandom_range(0, 48)),
                        32'($urandom_range(0, 60)), int'($urandom_range(4, 19)),
                        $urandom_range(0, 5) == 0);
            run_vec(rv, $sformatf("rnd%0d", i));
        end

        // Reset in the middle of WAIT: everything clears at once and no response follows.
        stub_hang = 1'b1;
        @(negedge clk);
        req_addr[31:0] = 32'd0;
        req_size[31:0] = 32'd3;
        req_valid = 2'b01;
        @(negedge clk);
        req_valid = '0;
        repeat (6) @(negedge clk);
        nreset = 1'b0;
        #1;
        chk_rst("rst_mid");
        @(negedge clk);
        nreset    = 1'b1;
        stub_hang = 1'b0;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) bad++;
        end
        chk("rst_mid", "spurious_rsp", 160'(bad), 0);

        // Fairness from reset: both requesters stay valid, grants alternate from 0.
        stub_lat = 10;
        req_addr = {32'd128, 32'd0};
        req_size = {32'd54, 32'd3};
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (rsp_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
            chk($sformatf("fair%0d", i), "rsp_valid", 160'(rsp_valid), 1);
            chk($sformatf("fair%0d", i), "rsp_id", 160'(rsp_id), 160'(i % 2));
            chk($sformatf("fair%0d", i), "rsp_hash", rsp_hash,
                (i % 2 == 1) ? sha1_ref(128, 54) : ABC_HASH);
            rsp_ready = 1'b1;
            if (i == 3) req_valid = '0;
            @(negedge clk);
            rsp_ready = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
